// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch sequencer and program selector for the 9-bit-instruction
// processor. Chooses one of three combinational ROMs per run and registers the
// fetched word into an IR. The IR is handed to the datapath over valid/ready.
// Taken-branch redirects are applied, and the run stops on HALT.
module prog_sequencer #(
  parameter logic [15:0] MAX_PC    = 16'd1023,
  parameter logic [8:0]  HALT_WORD = 9'h1B0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  prog_sel,
  output logic [15:0] rom_pc,
  input  logic [8:0]  rom_instr0,
  input  logic [8:0]  rom_instr1,
  input  logic [8:0]  rom_instr2,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        ir_format,
  output logic [3:0]  ir_opcode,
  output logic        ir_sign,
  output logic [2:0]  ir_operand,
  output logic [7:0]  ir_immediate,
  output logic [15:0] ir_pc,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] instr_count
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned IW    = 9;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [IW-1:0]      ir_q, ir_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]      fetched;
  logic               ld;
  logic               cons;

  assign ld   = (state_q == S_RUN) && (!ir_valid_q || ir_ready);
  assign cons = ir_valid_q && ir_ready;

  // ROM word for the current pc from the ROM chosen at start
  always_comb begin
    case (sel_q)
      2'd1:    fetched = rom_instr1;
      2'd2:    fetched = rom_instr2;
      default: fetched = rom_instr0;
    endcase
  end

  // Next-state and next-register computation for the whole sequencer
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sel_d      = sel_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    done_d     = 1'b0;
    fault_d    = fault_q;
    cnt_d      = cnt_q;

    // Every consumed instruction counts, saturating at all-ones
    if (cons && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && (prog_sel != 2'd3)) begin
          sel_d   = prog_sel;
          pc_d    = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (cons && br_taken) begin
          // Redirect wins over anything fetched this cycle; one bubble
          pc_d       = br_target;
          ir_valid_d = 1'b0;
        end else if (ld) begin
          if (pc_q > MAX_PC) begin
            fault_d    = 1'b1;
            ir_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            ir_d       = fetched;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (fetched == HALT_WORD) begin
              state_d = S_DRAIN;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
        end else if (cons) begin
          ir_valid_d = 1'b0;
        end
      end

      S_DRAIN: begin
        // Only the HALT is in flight; a branch on it is ignored
        if (cons) begin
          ir_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        ir_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      sel_q      <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sel_q      <= sel_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rom_pc       = pc_q;
  assign ir_valid     = ir_valid_q;
  assign ir_format    = ir_q[8];
  assign ir_opcode    = ir_q[7:4];
  assign ir_sign      = ir_q[3];
  assign ir_operand   = ir_q[2:0];
  assign ir_immediate = ir_q[7:0];
  assign ir_pc        = ir_pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with three behavioural ROMs.
module tb_prog_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  prog_sel;
  logic [15:0] rom_pc;
  logic [8:0]  rom_instr0, rom_instr1, rom_instr2;
  logic        ir_valid;
  logic        ir_ready;
  logic        ir_format;
  logic [3:0]  ir_opcode;
  logic        ir_sign;
  logic [2:0]  ir_operand;
  logic [7:0]  ir_immediate;
  logic [15:0] ir_pc;
  logic        br_taken;
  logic [15:0] br_target;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] instr_count;

  logic [8:0] rom0 [0:1023];
  logic [8:0] rom1 [0:1023];
  logic [8:0] rom2 [0:1023];

  int passed = 0;
  int total  = 0;

  prog_sequencer u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .prog_sel     (prog_sel),
    .rom_pc       (rom_pc),
    .rom_instr0   (rom_instr0),
    .rom_instr1   (rom_instr1),
    .rom_instr2   (rom_instr2),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .ir_format    (ir_format),
    .ir_opcode    (ir_opcode),
    .ir_sign      (ir_sign),
    .ir_operand   (ir_operand),
    .ir_immediate (ir_immediate),
    .ir_pc        (ir_pc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_instr0 = (rom_pc <= 16'd1023) ? rom0[rom_pc[9:0]] : 9'h000;
  assign rom_instr1 = (rom_pc <= 16'd1023) ? rom1[rom_pc[9:0]] : 9'h000;
  assign rom_instr2 = (rom_pc <= 16'd1023) ? rom2[rom_pc[9:0]] : 9'h000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(ir_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
    chk({tag, "_rompc"}, 32'(rom_pc), 32'd0);
    chk({tag, "_irpc"},  32'(ir_pc), 32'd0);
    chk({tag, "_ir"},    32'({ir_format, ir_immediate}), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      rom0[a] = {1'b0, 8'(a)};
      rom1[a] = {1'b0, ~8'(a)};
      rom2[a] = {1'b1, 4'h2, 4'(a)};
    end
    rom0[0]     = 9'h000;
    rom0[1]     = 9'h178;
    rom0[2]     = 9'h1B0;
    rom1[6]     = 9'h1B0;
    rom1[11]    = 9'h1B0;
    rom1[16'h42] = 9'h1B0;

    reset_n = 1'b0; start = 1'b0; prog_sel = 2'd0; ir_ready = 1'b1;
    br_taken = 1'b0; br_target = 16'h0000;
    tick(); tick();
    chk_reset_values("rst");

    // Straight-line program from ROM0
    reset_n = 1'b1; start = 1'b1; prog_sel = 2'd0;
    tick(); start = 1'b0;
    chk("a0_busy", 32'(busy), 32'd1);
    chk("a0_valid", 32'(ir_valid), 32'd0);
    tick();
    chk("a1_valid", 32'(ir_valid), 32'd1);
    chk("a1_irpc", 32'(ir_pc), 32'd0);
    chk("a1_imm", 32'(ir_immediate), 32'h00);
    chk("a1_rompc", 32'(rom_pc), 32'd1);
    tick();
    chk("a2_irpc", 32'(ir_pc), 32'd1);
    chk("a2_fields", 32'({ir_format, ir_opcode, ir_sign, ir_operand}), 32'h178);
    chk("a2_imm", 32'(ir_immediate), 32'h78);
    chk("a2_count", 32'(instr_count), 32'd1);
    tick();
    chk("a3_irpc", 32'(ir_pc), 32'd2);
    chk("a3_opcode", 32'(ir_opcode), 32'hB);
    chk("a3_format", 32'(ir_format), 32'd1);
    chk("a3_rompc", 32'(rom_pc), 32'd2);
    chk("a3_done", 32'(done), 32'd0);
    tick();
    chk("a4_done", 32'(done), 32'd1);
    chk("a4_busy", 32'(busy), 32'd0);
    chk("a4_valid", 32'(ir_valid), 32'd0);
    chk("a4_count", 32'(instr_count), 32'd3);
    chk("a4_rompc", 32'(rom_pc), 32'd2);
    tick();
    chk("a5_done", 32'(done), 32'd0);

    // Stall on the second instruction
    start = 1'b1; prog_sel = 2'd0;
    tick(); start = 1'b0;
    chk("b0_count", 32'(instr_count), 32'd0);
    tick(); tick();
    chk("b2_irpc", 32'(ir_pc), 32'd1);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bs_irpc", 32'(ir_pc), 32'd1);
      chk("bs_imm", 32'(ir_immediate), 32'h78);
      chk("bs_rompc", 32'(rom_pc), 32'd2);
      chk("bs_count", 32'(instr_count), 32'd1);
      chk("bs_valid", 32'(ir_valid), 32'd1);
    end
    ir_ready = 1'b1;
    tick();
    chk("b6_irpc", 32'(ir_pc), 32'd2);
    chk("b6_count", 32'(instr_count), 32'd2);
    tick();
    chk("b7_done", 32'(done), 32'd1);
    chk("b7_count", 32'(instr_count), 32'd3);
    tick();

    // Branches from ROM1, each with a HALT on the wrong path
    start = 1'b1; prog_sel = 2'd1;
    tick(); start = 1'b0;
    repeat (6) tick();
    chk("c6_irpc", 32'(ir_pc), 32'd5);
    chk("c6_imm", 32'(ir_immediate), 32'hFA);
    br_taken = 1'b1; br_target = 16'h0040;
    tick(); br_taken = 1'b0;
    chk("c7_valid", 32'(ir_valid), 32'd0);
    chk("c7_rompc", 32'(rom_pc), 32'h40);
    chk("c7_busy", 32'(busy), 32'd1);
    chk("c7_count", 32'(instr_count), 32'd6);
    tick();
    chk("c8_irpc", 32'(ir_pc), 32'h40);
    chk("c8_imm", 32'(ir_immediate), 32'hBF);
    chk("c8_valid", 32'(ir_valid), 32'd1);
    tick();
    chk("c9_irpc", 32'(ir_pc), 32'h41);
    chk("c9_rompc", 32'(rom_pc), 32'h42);
    br_taken = 1'b1; br_target = 16'd10;
    tick(); br_taken = 1'b0;
    chk("c10_valid", 32'(ir_valid), 32'd0);
    chk("c10_rompc", 32'(rom_pc), 32'd10);
    chk("c10_busy", 32'(busy), 32'd1);
    tick();
    chk("c11_irpc", 32'(ir_pc), 32'd10);
    chk("c11_imm", 32'(ir_immediate), 32'hF5);
    tick();
    chk("c12_irpc", 32'(ir_pc), 32'd11);
    chk("c12_imm", 32'(ir_immediate), 32'hB0);
    chk("c12_count", 32'(instr_count), 32'd9);
    br_taken = 1'b1; br_target = 16'h0077;
    tick(); br_taken = 1'b0;
    chk("c13_done", 32'(done), 32'd1);
    chk("c13_rompc", 32'(rom_pc), 32'd11);
    chk("c13_count", 32'(instr_count), 32'd10);
    chk("c13_busy", 32'(busy), 32'd0);
    tick();

    // prog_sel=3 leaves the sequencer idle
    start = 1'b1; prog_sel = 2'd3;
    tick(); start = 1'b0;
    chk("d0_busy", 32'(busy), 32'd0);
    chk("d0_valid", 32'(ir_valid), 32'd0);
    chk("d0_rompc", 32'(rom_pc), 32'd11);
    tick();
    chk("d1_busy", 32'(busy), 32'd0);

    // ROM2 run, then branch to the last legal address and fall off the end
    start = 1'b1; prog_sel = 2'd2;
    tick(); start = 1'b0;
    tick();
    chk("e1_fields", 32'({ir_format, ir_opcode, ir_sign, ir_operand}), 32'h120);
    chk("e1_irpc", 32'(ir_pc), 32'd0);
    tick();
    chk("e2_irpc", 32'(ir_pc), 32'd1);
    chk("e2_operand", 32'(ir_operand), 32'd1);
    br_taken = 1'b1; br_target = 16'h03FF;
    tick(); br_taken = 1'b0;
    chk("e3_valid", 32'(ir_valid), 32'd0);
    chk("e3_rompc", 32'(rom_pc), 32'h3FF);
    tick();
    chk("e4_irpc", 32'(ir_pc), 32'h3FF);
    chk("e4_imm", 32'(ir_immediate), 32'h2F);
    chk("e4_fault", 32'(fault), 32'd0);
    chk("e4_rompc", 32'(rom_pc), 32'h400);
    tick();
    chk("e5_fault", 32'(fault), 32'd1);
    chk("e5_busy", 32'(busy), 32'd0);
    chk("e5_valid", 32'(ir_valid), 32'd0);
    chk("e5_count", 32'(instr_count), 32'd3);
    tick();
    chk("e6_fault", 32'(fault), 32'd1);

    // Restart clears fault; reset mid-run aborts without done
    start = 1'b1; prog_sel = 2'd0;
    tick(); start = 1'b0;
    chk("f0_fault", 32'(fault), 32'd0);
    chk("f0_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("f2_irpc", 32'(ir_pc), 32'd1);
    reset_n = 1'b0;
    tick();
    chk_reset_values("midrst");
    reset_n = 1'b1;
    tick();
    chk("f4_done", 32'(done), 32'd0);
    chk("f4_busy", 32'(busy), 32'd0);
    tick();
    chk("f5_done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Fetch sequencer and program selector for the 9-bit-instruction processor. Drives the PC into three combinational instruction ROMs, selects one ROM per run, and registers the fetched fields into an instruction register. Hands them to the datapath over a valid/ready handshake, applies taken-branch redirects, and stops on HALT. Sits between the instruction ROMs and the decode/execute datapath.

## Interface
- MAX_PC, 16'd1023: the highest legal fetch address; fetching beyond it raises `fault`.
- HALT_WORD, 9'h1B0: the HALT encoding, fields format=1, opcode=4'b1011, sign=0, operand=3'b000.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- prog_sel  in  2  ROM select sampled with `start`; 0..2 valid; 3 means `start` is ignored.
- rom_pc  out  16  address to all ROMs; equals the internal `pc` register.
- rom_instr0 / rom_instr1 / rom_instr2  in  9 each  combinational ROM words for `rom_pc`.
- ir_valid  out  1  IR holds an instruction for the datapath.
- ir_ready  in  1  datapath consumes the IR this cycle when `ir_valid` is 1.
- ir_format  out  1  IR bit 8.
- ir_opcode  out  4  IR bits 7:4.
- ir_sign  out  1  IR bit 3.
- ir_operand  out  3  IR bits 2:0.
- ir_immediate  out  8  IR bits 7:0.
- ir_pc  out  16  address the IR word was fetched from.
- br_taken  in  1  the consumed instruction redirects the PC; qualified by `ir_valid & ir_ready`.
- br_target  in  16  redirect address.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  one-cycle pulse when the HALT instruction is consumed.
- fault  out  1  sticky; set on a fetch past MAX_PC; cleared by `start` or reset.
- instr_count  out  16  count of consumed instructions this run; saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN, DRAIN.
- Reset (reset_n low at an edge): state=IDLE, pc=0, sel=0, IR fields=0, ir_pc=0, ir_valid=0, done=0, fault=0, instr_count=0.
- `fetched` is the ROM word picked by the `sel` register (rom_instrN). Combinational output; the ROM has no latency.
- Load enable: `ld = (state==RUN) & (!ir_valid | ir_ready)`. A consume is `cons = ir_valid & ir_ready`.
- IDLE: on `start` with prog_sel≠3:
  - sel <= prog_sel, pc <= 0, instr_count <= 0, fault <= 0;
  - go to RUN.
- RUN, on a cons with br_taken:
  - pc <= br_target, ir_valid <= 0. This is a 1-cycle bubble; the wrong-path word is discarded.
  - A HALT fetched in the same cycle is ignored. The branch wins.
- RUN, on ld without a redirect:
  - if pc > MAX_PC: fault <= 1, ir_valid <= 0, go to IDLE;
  - else: IR <= fetched, ir_pc <= pc, ir_valid <= 1, pc <= pc+1 (16-bit wrap 16'hFFFF→0).
  - If fetched == HALT_WORD, go to DRAIN and pc holds.
- RUN, cons without ld: ir_valid <= 0. This cannot occur, since ld covers every cons in RUN.
- DRAIN: no fetch. On cons (the HALT is consumed), in priority order:
  - if br_taken, it is ignored;
  - ir_valid <= 0, done pulses for 1 cycle, go to IDLE.
- Every cons increments instr_count, saturating. HALT counts as one.
- `start` in RUN or DRAIN is ignored.
- Reset asserted mid-run aborts immediately to the reset values. No `done` pulse is produced.

## Timing
- Edge E0 samples `start` → pc=0, RUN.
- Edge E1: IR = word at address 0, ir_valid=1, pc=1.
- With ir_ready held at 1, the sequencer issues one instruction per cycle.
- Branch consumed at edge Ek → ir_valid=0 after Ek. The target word is valid after Ek+1, and ir_pc=br_target.
- Stall: ir_ready=0 holds IR, ir_pc and pc unchanged. No fetch occurs.
- `done` is high for the single cycle after the edge that consumes HALT. busy=0 in that same cycle.
- `fault` is visible the cycle after the offending edge and stays set until the next honoured `start`.

## Test plan
- Straight-line, ir_ready=1:
  - Stimulus: ROM0 = {9'h000, 9'h178, 9'h1B0}, start with prog_sel=0.
  - Response: IR sequence 000, 178, 1B0 at ir_pc 0, 1, 2; done 1 cycle after HALT is consumed; instr_count=3.
- Stall:
  - Stimulus: ir_ready=0 for 3 cycles during the 2nd instruction.
  - Response: IR and ir_pc stable; rom_pc stays 2; count excludes stalled cycles.
- Branch:
  - Stimulus: br_taken=1, br_target=16'h0040 when consuming ir_pc=5.
  - Response: one bubble; next IR is from 0x40 with ir_pc=16'h0040; the word at 6 is never issued.
- Branch vs HALT:
  - Stimulus: HALT at address 6, branch consumed at 5 to target 10.
  - Response: no DRAIN; execution continues at 10.
- prog_sel:
  - Stimulus: prog_sel=2 selects ROM2 words; prog_sel=3 with start.
  - Response: ROM2 words issued for sel=2; for sel=3 the sequencer stays IDLE and busy stays 0.
- Fault and reset:
  - Stimulus: MAX_PC=3 with no HALT in 0..3.
  - Response: fault=1 after the fetch attempt at 4; return to IDLE.
  - Stimulus: reset_n low mid-run.
  - Response: all outputs at reset values next cycle; no done pulse.
